dff_pipe: RTL
=============

# dff_pipe

Parametrised multi-stage register pipeline: the generalised successor of the single-bit D flip-flop, carrying a WIDTH-bit data word plus a valid bit through DEPTH stages. It adds a clock enable (stall), a synchronous clear, a selectable tap, and a running occupancy count. It sits wherever the design needs a fixed-latency, stallable delay line, and embeds its own behavioural assertions.

## Interface
- WIDTH, 8, data word width; legal range 1 or more.
- DEPTH, 4, number of register stages and the latency in enabled cycles; legal range 1 or more.
- RST_VAL, '0, WIDTH-bit value loaded into every data stage on reset or clear.
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset. Clock is clk; reset is asynchronous and active-low.
- en  input  1  shift enable; 0 holds every stage.
- clr  input  1  synchronous clear; overrides en.
- din_valid  input  1  qualifies din.
- din  input  WIDTH  input data word.
- dout_valid  output  1  valid bit of the last stage (DEPTH-1).
- dout  output  WIDTH  data of the last stage.
- tap_sel  input  TAPW  stage index to observe; TAPW = max(1, $clog2(DEPTH)).
- tap_valid  output  1  valid bit of stage tap_sel; 0 if tap_sel ≥ DEPTH.
- tap_data  output  WIDTH  data of stage tap_sel; RST_VAL if tap_sel ≥ DEPTH.
- occ  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

## Operation
- Reset (rst_n=0, asynchronous): all data stages are set to RST_VAL, all valid bits to 0, and occ to 0. dout=RST_VAL, dout_valid=0.
- Priority per posedge: clr, then en, then hold.
- clr=1: same effect as reset, applied on the clock edge; en is ignored.
- en=1, clr=0: stage0 ← {din_valid, din}; stage i ← stage i-1 for 1 ≤ i < DEPTH. The last stage's contents leave the pipe.
- en=0, clr=0: every stage and occ hold their values; din and din_valid are ignored.
- Data is stored regardless of din_valid. Invalid words still move through the pipe, with their valid bit at 0.
- occ is a registered counter, not a popcount. On an enabled shift it changes by +1 if din_valid and the last stage is not valid, by -1 if the last stage is valid and din_valid=0, and is otherwise unchanged. It must always equal the popcount of the valid bits.
- tap_* outputs are combinational muxes of stage state; they do not depend on din.

## Timing
- Latency: a word presented with en=1 at edge k appears on dout after edge k+DEPTH-1, provided en=1 on every intervening edge. Each en=0 edge adds one cycle.
- DEPTH=1: dout is stage0; occ is 0 or 1.
- occ updates on the same edge as the stage shift. It is never 0→DEPTH in one edge unless DEPTH=1.
- clr and en asserted together: the result is cleared; the input word is lost.
- Reset asserted mid-stream: outputs go to reset values immediately, without waiting for a clock edge. On deassertion, the first enabled edge loads stage0 only.
- Outputs dout, dout_valid and occ are registered; there is no combinational path from any input to them.

## Structure
- Package dff_pipe_pkg holds:
  - the stage struct typedef {logic valid; logic [WIDTH-1:0] data}, provided as a parametrised-width helper or defined locally if the toolchain lacks parametrised typedefs;
  - a function occ_w(depth) returning $clog2(depth+1).
- Sub-module dff_stage contains one register stage with async reset, sync clear and enable. dff_pipe instantiates it DEPTH times in a generate loop.
- Embedded concurrent assertions (disabled while rst_n=0), each reporting via $error with $time:
  - en && !clr |=> stage0 == $past({din_valid, din});
  - clr |=> occ == 0 && !dout_valid;
  - !en && !clr |=> $stable(occ) && $stable(dout);
  - occ == $countones(valid bits) at every edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random din → dout=RST_VAL, dout_valid=0, occ=0. Release, then drive din=8'hA5 valid with en=1 → dout=8'hA5 and dout_valid=1 exactly 4 edges later (DEPTH=4).
- Stall: stream 8'h01..8'h06 valid, with en=0 for 2 cycles mid-stream → order preserved, latency 6, occ frozen during the stall.
- Bubbles: alternate din_valid 1/0 for 8 cycles → occ settles at 2, dout_valid toggles every cycle, and the invalid words' data still propagates.
- Clear priority: pipe full (occ=4), then clr=1 with en=1 and din=8'hFF valid → next edge: occ=0, all valid bits 0, 8'hFF not captured.
- Tap and range: sweep tap_sel 0..3 on a full pipe holding 8'h10, 8'h20, 8'h30, 8'h40 → tap_data matches stage contents. With DEPTH=3 and tap_sel=3 → tap_valid=0, tap_data=RST_VAL.
- Async reset mid-stream: pulse rst_n low between edges with occ=3 → outputs clear before the next edge, and no assertion fires.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared sizing helpers and defaults for the dff_pipe delay line.
// The stage struct depends on WIDTH, so each module declares it locally.
package dff_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tap_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline register stage: valid bit plus data word.
// Asynchronous reset, synchronous clear and shift enable.
module dff_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = RST_VAL;
        end else if (en) begin
            valid_d = valid_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable fixed-latency delay line of DEPTH stages carrying {valid, data},
// with synchronous clear, a stage tap and a registered occupancy counter.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              TAPW    = tap_w(DEPTH),
    localparam int              OCCW    = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout,
    input  logic [TAPW-1:0]  tap_sel,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_data,
    output logic [OCCW-1:0]  occ
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_in [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];

    assign stage_in[0] = {din_valid, din};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i > 0) begin : g_link
            assign stage_in[i] = {valid_vec[i-1], data_arr[i-1]};
        end
        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .clr       (clr),
            .valid_in  (stage_in[i].valid),
            .data_in   (stage_in[i].data),
            .valid_out (valid_vec[i]),
            .data_out  (data_arr[i])
        );
    end

    assign dout_valid = valid_vec[DEPTH-1];
    assign dout       = data_arr[DEPTH-1];

    // Counter tracks entry/exit of valid words instead of summing valid bits.
    logic [OCCW-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            if (din_valid && !valid_vec[DEPTH-1]) begin
                occ_d = occ_q + OCCW'(1);
            end else if (!din_valid && valid_vec[DEPTH-1]) begin
                occ_d = occ_q - OCCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

    always_comb begin
        tap_valid = 1'b0;
        tap_data  = RST_VAL;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAPW'(i)) begin
                tap_valid = valid_vec[i];
                tap_data  = data_arr[i];
            end
        end
    end

    // Low after any reset until the first edge, so checks spanning an
    // asynchronous reset pulse between two edges are skipped.
    logic armed_q, armed_d;

    always_comb begin
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        en && !clr |=> !armed_q || ({valid_vec[0], data_arr[0]} == $past({din_valid, din})))
        else $error("dff_pipe stage0 load error at %0t", $time);

    a_clear: assert property (@(posedge clk) disable iff (!rst_n)
        clr |=> (occ_q == '0) && !valid_vec[DEPTH-1])
        else $error("dff_pipe clear error at %0t", $time);

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !en && !clr |=> !armed_q || ($stable(occ_q) && $stable(data_arr[DEPTH-1])))
        else $error("dff_pipe hold error at %0t", $time);

    a_occ: assert property (@(posedge clk) disable iff (!rst_n)
        int'(occ_q) == $countones(valid_vec))
        else $error("dff_pipe occupancy error at %0t", $time);

endmodule
